// File: rtl/decode_branch_resolver.sv
// Decode-stage control, operand forwarding and branch resolution with the D/E register.
// Optional REGIMM_BRANCH_EN adds decode of op 000001 (bltz/bgez).
module decode_branch_resolver (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ClearE,
  input  logic [31:0] IRD,
  input  logic [31:0] RS_RF,
  input  logic [31:0] RT_RF,
  input  logic [31:0] PC4_E,
  input  logic [31:0] AO,
  input  logic [31:0] PC4_M,
  input  logic [31:0] WD_W,
  input  logic [2:0]  Fwd_RS_src,
  input  logic [2:0]  Fwd_RT_src,
  output logic [1:0]  EXTop,
  output logic [1:0]  PCsrc,
  output logic        NPCsrc,
  output logic        Branch,
  output logic [31:0] RS_fwd,
  output logic [31:0] RT_fwd,
  output logic [31:0] IRE,
  output logic [31:0] RSE,
  output logic [31:0] RTE
);

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SW      = 6'b101011;

  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;

  localparam logic [1:0] EXT_ZERO   = 2'd0;
  localparam logic [1:0] EXT_SIGN   = 2'd1;
  localparam logic [1:0] EXT_LUI    = 2'd2;

  localparam logic [1:0] PC_SEQ     = 2'd0;
  localparam logic [1:0] PC_BRANCH  = 2'd1;
  localparam logic [1:0] PC_JUMP    = 2'd2;
  localparam logic [1:0] PC_REG     = 2'd3;

  logic [5:0] op;
  logic [5:0] funct;

  assign op    = IRD[31:26];
  assign funct = IRD[5:0];

  // Sources 5..7 are unused encodings and fall back to the register file.
  function automatic logic [31:0] fwd_sel(input logic [2:0]  src,
                                          input logic [31:0] rf,
                                          input logic [31:0] pc4_e,
                                          input logic [31:0] ao,
                                          input logic [31:0] pc4_m,
                                          input logic [31:0] wd_w);
    logic [31:0] val;
    case (src)
      3'd1:    val = pc4_e;
      3'd2:    val = ao;
      3'd3:    val = pc4_m;
      3'd4:    val = wd_w;
      default: val = rf;
    endcase
    return val;
  endfunction

  assign RS_fwd = fwd_sel(Fwd_RS_src, RS_RF, PC4_E, AO, PC4_M, WD_W);
  assign RT_fwd = fwd_sel(Fwd_RT_src, RT_RF, PC4_E, AO, PC4_M, WD_W);

  logic rs_zero;
  logic rs_neg;
  logic rs_eq_rt;

  assign rs_zero  = (RS_fwd == 32'd0);
  assign rs_neg   = RS_fwd[31];
  assign rs_eq_rt = (RS_fwd == RT_fwd);

`ifdef REGIMM_BRANCH_EN
  localparam logic [4:0] RT_BLTZ = 5'b00000;
  localparam logic [4:0] RT_BGEZ = 5'b00001;

  logic [4:0] rt_code;
  assign rt_code = IRD[20:16];
`endif

  always_comb begin
    EXTop  = EXT_ZERO;
    PCsrc  = PC_SEQ;
    NPCsrc = 1'b0;
    Branch = 1'b0;
    case (op)
      // addu/subu and unknown functs all leave the controls at zero.
      OP_SPECIAL: begin
        if (funct == FN_JR || funct == FN_JALR) PCsrc = PC_REG;
      end
      OP_ORI: EXTop = EXT_ZERO;
      OP_LW, OP_SW: EXTop = EXT_SIGN;
      OP_LUI: EXTop = EXT_LUI;
      OP_BEQ: begin
        EXTop  = EXT_SIGN;
        PCsrc  = PC_BRANCH;
        Branch = rs_eq_rt;
      end
      OP_BNE: begin
        EXTop  = EXT_SIGN;
        PCsrc  = PC_BRANCH;
        Branch = !rs_eq_rt;
      end
      OP_BLEZ: begin
        EXTop  = EXT_SIGN;
        PCsrc  = PC_BRANCH;
        Branch = rs_neg || rs_zero;
      end
      OP_BGTZ: begin
        EXTop  = EXT_SIGN;
        PCsrc  = PC_BRANCH;
        Branch = !rs_neg && !rs_zero;
      end
      OP_J, OP_JAL: begin
        PCsrc  = PC_JUMP;
        NPCsrc = 1'b1;
      end
`ifdef REGIMM_BRANCH_EN
      OP_REGIMM: begin
        if (rt_code == RT_BLTZ) begin
          EXTop  = EXT_SIGN;
          PCsrc  = PC_BRANCH;
          Branch = rs_neg;
        end else if (rt_code == RT_BGEZ) begin
          EXTop  = EXT_SIGN;
          PCsrc  = PC_BRANCH;
          Branch = !rs_neg;
        end
      end
`else
      OP_REGIMM: ;
`endif
      default: ;
    endcase
  end

  // Reset and ClearE both zero the stage, turning it into a nop bubble.
  always_ff @(posedge Clk) begin
    if (Reset || ClearE) begin
      IRE <= 32'd0;
      RSE <= 32'd0;
      RTE <= 32'd0;
    end else begin
      IRE <= IRD;
      RSE <= RS_fwd;
      RTE <= RT_fwd;
    end
  end

endmodule

// File: tb/tb_decode_branch_resolver.sv
// Self-checking bench for decode_branch_resolver: directed cases plus randomized
// decode/forward/branch and pipeline-register checks against a behavioural model.
module tb_decode_branch_resolver;
  logic        Clk = 1'b0;
  logic        Reset, ClearE;
  logic [31:0] IRD, RS_RF, RT_RF, PC4_E, AO, PC4_M, WD_W;
  logic [2:0]  Fwd_RS_src, Fwd_RT_src;
  logic [1:0]  EXTop, PCsrc;
  logic        NPCsrc, Branch;
  logic [31:0] RS_fwd, RT_fwd, IRE, RSE, RTE;

  int pass_cnt = 0;
  int total_cnt = 0;

  decode_branch_resolver dut (
    .Clk(Clk), .Reset(Reset), .ClearE(ClearE), .IRD(IRD),
    .RS_RF(RS_RF), .RT_RF(RT_RF), .PC4_E(PC4_E), .AO(AO),
    .PC4_M(PC4_M), .WD_W(WD_W), .Fwd_RS_src(Fwd_RS_src),
    .Fwd_RT_src(Fwd_RT_src), .EXTop(EXTop), .PCsrc(PCsrc),
    .NPCsrc(NPCsrc), .Branch(Branch), .RS_fwd(RS_fwd), .RT_fwd(RT_fwd),
    .IRE(IRE), .RSE(RSE), .RTE(RTE)
  );

  always #5 Clk = ~Clk;

  // Reference: forwarded value by source list position.
  function automatic logic [31:0] m_fwd(input logic [2:0] src, input logic [31:0] rf);
    logic [31:0] table_v [8];
    table_v = '{rf, PC4_E, AO, PC4_M, WD_W, rf, rf, rf};
    return table_v[src];
  endfunction

  // Reference: {EXTop, PCsrc, NPCsrc, Branch} from the instruction rules.
  function automatic logic [5:0] m_ctrl(input logic [31:0] ir, input logic [31:0] rs,
                                        input logic [31:0] rt);
    int op, fn, rtc;
    longint srs;
    logic [1:0] ext, pcs;
    logic npc, br;
    op = int'(ir[31:26]); fn = int'(ir[5:0]); rtc = int'(ir[20:16]);
    srs = longint'($signed(rs));
    ext = 0; pcs = 0; npc = 0; br = 0;
    if (op == 0 && (fn == 8 || fn == 9)) pcs = 3;
    else if (op == 13) ext = 0;
    else if (op == 35 || op == 43) ext = 1;
    else if (op == 15) ext = 2;
    else if (op == 2 || op == 3) begin pcs = 2; npc = 1; end
    else if (op >= 4 && op <= 7) begin
      ext = 1; pcs = 1;
      if (op == 4) br = (rs == rt);
      if (op == 5) br = (rs != rt);
      if (op == 6) br = (srs <= 0);
      if (op == 7) br = (srs > 0);
    end
`ifdef REGIMM_BRANCH_EN
    else if (op == 1 && (rtc == 0 || rtc == 1)) begin
      ext = 1; pcs = 1;
      br = (rtc == 0) ? (srs < 0) : (srs >= 0);
    end
`endif
    return {ext, pcs, npc, br};
  endfunction

  task automatic drive(input logic [31:0] ir, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [2:0] srs, input logic [2:0] srt);
    IRD = ir; RS_RF = rs; RT_RF = rt; Fwd_RS_src = srs; Fwd_RT_src = srt;
  endtask

  task automatic test_reset;
    @(negedge Clk);
    Reset = 1; ClearE = 0;
    drive(32'h8C220004, 32'h11, 32'h22, 0, 0);
    @(posedge Clk); #1;
    total_cnt++;
    if ({IRE, RSE, RTE} !== 96'd0) $display("FAIL reset regs got %h %h %h want 0", IRE, RSE, RTE);
    else pass_cnt++;
    Reset = 0;
  endtask

  task automatic test_beq;
    logic [5:0] got;
    @(negedge Clk);
    drive(32'h10220003, 32'h5, 32'h5, 0, 0); #1;
    got = {EXTop, PCsrc, NPCsrc, Branch};
    total_cnt++;
    if (got !== 6'b01_01_0_1) $display("FAIL beq_taken got %b want 010101", got);
    else pass_cnt++;
    RT_RF = 32'h6; #1;
    got = {EXTop, PCsrc, NPCsrc, Branch};
    total_cnt++;
    if (got !== 6'b01_01_0_0) $display("FAIL beq_not_taken got %b want 010100", got);
    else pass_cnt++;
  endtask

  task automatic test_forward;
    logic [31:0] want [8];
    want = '{32'h0, 32'h3008, 32'h1234, 32'h300C, 32'hBEEF, 32'h0, 32'h0, 32'h0};
    @(negedge Clk);
    AO = 32'h1234; PC4_E = 32'h3008; PC4_M = 32'h300C; WD_W = 32'hBEEF;
    for (int s = 0; s < 8; s++) begin
      drive(32'h0, 32'h0, 32'h0, 3'(s), 3'(7 - s)); #1;
      total_cnt++;
      if (RS_fwd !== want[s]) $display("FAIL fwd_rs src=%0d got %h want %h", s, RS_fwd, want[s]);
      else pass_cnt++;
      total_cnt++;
      if (RT_fwd !== want[7 - s]) $display("FAIL fwd_rt src=%0d got %h want %h", 7 - s, RT_fwd, want[7 - s]);
      else pass_cnt++;
    end
  endtask

  task automatic test_signed_branches;
    @(negedge Clk);
    drive(32'h1C200005, 32'h80000000, 0, 0, 0); #1;
    total_cnt++;
    if (Branch !== 1'b0) $display("FAIL bgtz_min got %b want 0", Branch); else pass_cnt++;
    drive(32'h1C200005, 32'h1, 0, 0, 0); #1;
    total_cnt++;
    if (Branch !== 1'b1) $display("FAIL bgtz_one got %b want 1", Branch); else pass_cnt++;
    drive(32'h18200005, 32'h0, 0, 0, 0); #1;
    total_cnt++;
    if (Branch !== 1'b1) $display("FAIL blez_zero got %b want 1", Branch); else pass_cnt++;
    AO = 32'h1;
    drive(32'h14220005, 32'h99, 32'h1, 2, 0); #1;
    total_cnt++;
    if (Branch !== 1'b0) $display("FAIL bne_fwd got %b want 0", Branch); else pass_cnt++;
  endtask

  task automatic test_decode;
    logic [31:0] irs [6];
    logic [5:0]  want [6];
    irs  = '{32'h0C000100, 32'h03E00008, 32'h3C011234, 32'h34210001, 32'hFC000000, 32'h00000000};
    want = '{6'b00_10_1_0, 6'b00_11_0_0, 6'b10_00_0_0, 6'b00_00_0_0, 6'b00_00_0_0, 6'b00_00_0_0};
    @(negedge Clk);
    PC4_M = 32'h0000_3010;
    for (int i = 0; i < 6; i++) begin
      drive(irs[i], 32'hA5A5_0000, 32'h0, 3, 0); #1;
      total_cnt++;
      if ({EXTop, PCsrc, NPCsrc, Branch} !== want[i])
        $display("FAIL decode ir=%h got %b want %b", irs[i], {EXTop, PCsrc, NPCsrc, Branch}, want[i]);
      else pass_cnt++;
    end
    drive(32'h03E00008, 32'hA5A5_0000, 32'h0, 3, 0); #1;
    total_cnt++;
    if (RS_fwd !== 32'h3010) $display("FAIL jr_target got %h want 00003010", RS_fwd);
    else pass_cnt++;
  endtask

  task automatic test_regimm;
    logic [5:0] w_lt, w_ge;
`ifdef REGIMM_BRANCH_EN
    w_lt = 6'b01_01_0_1; w_ge = 6'b01_01_0_1;
`else
    w_lt = 6'b0; w_ge = 6'b0;
`endif
    @(negedge Clk);
    drive(32'h04200000, 32'hFFFFFFFF, 0, 0, 0); #1;
    total_cnt++;
    if ({EXTop, PCsrc, NPCsrc, Branch} !== w_lt)
      $display("FAIL bltz got %b want %b", {EXTop, PCsrc, NPCsrc, Branch}, w_lt);
    else pass_cnt++;
    drive(32'h04210000, 32'h0, 0, 0, 0); #1;
    total_cnt++;
    if ({EXTop, PCsrc, NPCsrc, Branch} !== w_ge)
      $display("FAIL bgez got %b want %b", {EXTop, PCsrc, NPCsrc, Branch}, w_ge);
    else pass_cnt++;
    drive(32'h04250000, 32'h0, 0, 0, 0); #1;
    total_cnt++;
    if ({EXTop, PCsrc, NPCsrc, Branch} !== 6'b0)
      $display("FAIL regimm_other got %b want 000000", {EXTop, PCsrc, NPCsrc, Branch});
    else pass_cnt++;
  endtask

  task automatic test_random_decode;
    logic [5:0] ops [14];
    logic [5:0] fns [5];
    logic [31:0] ir, rs, rt, pool [4];
    logic [5:0] exp_c;
    logic [31:0] exp_rs, exp_rt;
    ops = '{0, 1, 2, 3, 4, 5, 6, 7, 13, 15, 35, 43, 8, 63};
    fns = '{6'h21, 6'h23, 6'h08, 6'h09, 6'h2A};
    for (int n = 0; n < 200; n++) begin
      @(negedge Clk);
      pool = '{32'h0, 32'h1, 32'h80000000, $urandom};
      PC4_E = pool[$urandom_range(0, 3)]; AO = pool[$urandom_range(0, 3)];
      PC4_M = pool[$urandom_range(0, 3)]; WD_W = pool[$urandom_range(0, 3)];
      rs = pool[$urandom_range(0, 3)]; rt = pool[$urandom_range(0, 3)];
      ir = $urandom;
      ir[31:26] = ops[$urandom_range(0, 13)];
      if ($urandom_range(0, 1) == 1) ir[5:0] = fns[$urandom_range(0, 4)];
      if ($urandom_range(0, 1) == 1) ir[20:16] = 5'($urandom_range(0, 1));
      drive(ir, rs, rt, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))); #1;
      exp_rs = m_fwd(Fwd_RS_src, rs);
      exp_rt = m_fwd(Fwd_RT_src, rt);
      exp_c  = m_ctrl(ir, exp_rs, exp_rt);
      total_cnt++;
      if ({RS_fwd, RT_fwd} !== {exp_rs, exp_rt})
        $display("FAIL rand_fwd got %h %h want %h %h", RS_fwd, RT_fwd, exp_rs, exp_rt);
      else pass_cnt++;
      total_cnt++;
      if ({EXTop, PCsrc, NPCsrc, Branch} !== exp_c)
        $display("FAIL rand_ctrl ir=%h got %b want %b", ir, {EXTop, PCsrc, NPCsrc, Branch}, exp_c);
      else pass_cnt++;
    end
  endtask

  task automatic test_pipeline;
    logic [31:0] e_ir, e_rs, e_rt;
    @(negedge Clk);
    Reset = 0; ClearE = 0;
    drive(32'h8C220004, 32'h7, 32'h9, 0, 0);
    @(posedge Clk); #1;
    total_cnt++;
    if ({IRE, RSE, RTE} !== {32'h8C220004, 32'h7, 32'h9})
      $display("FAIL pipe_load got %h %h %h want 8c220004 7 9", IRE, RSE, RTE);
    else pass_cnt++;
    @(negedge Clk); ClearE = 1;
    @(posedge Clk); #1;
    total_cnt++;
    if ({IRE, RSE, RTE} !== 96'd0) $display("FAIL pipe_clear got %h %h %h want 0", IRE, RSE, RTE);
    else pass_cnt++;
    for (int n = 0; n < 150; n++) begin
      @(negedge Clk);
      Reset  = ($urandom_range(0, 9) == 0);
      ClearE = ($urandom_range(0, 5) == 0);
      PC4_E = $urandom; AO = $urandom; PC4_M = $urandom; WD_W = $urandom;
      drive($urandom, $urandom, $urandom, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      #1;
      if (Reset || ClearE) begin
        e_ir = 0; e_rs = 0; e_rt = 0;
      end else begin
        e_ir = IRD; e_rs = m_fwd(Fwd_RS_src, RS_RF); e_rt = m_fwd(Fwd_RT_src, RT_RF);
      end
      @(posedge Clk); #1;
      total_cnt++;
      if ({IRE, RSE, RTE} !== {e_ir, e_rs, e_rt})
        $display("FAIL pipe_rand got %h %h %h want %h %h %h", IRE, RSE, RTE, e_ir, e_rs, e_rt);
      else pass_cnt++;
    end
    Reset = 0; ClearE = 0;
  endtask

  initial begin
    Reset = 1; ClearE = 0;
    IRD = 0; RS_RF = 0; RT_RF = 0; PC4_E = 0; AO = 0; PC4_M = 0; WD_W = 0;
    Fwd_RS_src = 0; Fwd_RT_src = 0;
    test_reset();
    test_beq();
    test_forward();
    test_signed_branches();
    test_decode();
    test_regimm();
    test_random_decode();
    test_pipeline();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/decode_branch_resolver.md
Name: decode_branch_resolver

Overview:
- Decode-stage (D) control and branch resolution block of the 5-stage MIPS pipeline.
- Decodes the D-stage instruction into extender and next-PC controls.
- Selects forwarded RS/RT operands from later stages and compares them to resolve branches in D.
- Registers the instruction and forwarded operands into the D/E pipeline register, with flush.

Parameters:
- None. Datapath width is fixed at 32 bits; forward select is fixed at 3 bits.

Ports:
- Clk  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high reset
- ClearE  in  1  flush D/E register (bubble insert)
- IRD  in  32  D-stage instruction
- RS_RF  in  32  register-file read of IRD[25:21]
- RT_RF  in  32  register-file read of IRD[20:16]
- PC4_E  in  32  link value forwarded from E
- AO  in  32  ALU result forwarded from M
- PC4_M  in  32  link value forwarded from M
- WD_W  in  32  write-back data from W
- Fwd_RS_src  in  3  RS forward select
- Fwd_RT_src  in  3  RT forward select
- EXTop  out  2  0 = zero-extend, 1 = sign-extend, 2 = load-upper (imm<<16)
- PCsrc  out  2  0 = PC+4, 1 = branch, 2 = j/jal, 3 = jr/jalr
- NPCsrc  out  1  0 = branch-offset target, 1 = 26-bit jump index target
- Branch  out  1  branch condition true
- RS_fwd  out  32  forwarded RS; also used as jr/jalr target
- RT_fwd  out  32  forwarded RT
- IRE  out  32  registered instruction
- RSE  out  32  registered RS_fwd
- RTE  out  32  registered RT_fwd

Behaviour:
- Decode is combinational from IRD[31:26] (op) and IRD[5:0] (funct).
- op=000000, funct 100001 addu / 100011 subu: EXTop=0, PCsrc=0, NPCsrc=0.
- op=000000, funct 001000 jr / 001001 jalr: PCsrc=3, others 0.
- ori 001101: EXTop=0.
- lw 100011 / sw 101011: EXTop=1.
- lui 001111: EXTop=2.
- beq 000100, bne 000101, blez 000110, bgtz 000111: EXTop=1, PCsrc=1, NPCsrc=0.
- j 000010 / jal 000011: PCsrc=2, NPCsrc=1.
- Any other op or funct, including nop 0x00000000: all control outputs 0.
- Forward mux, identical for RS and RT: src 0 = RF value, 1 = PC4_E, 2 = AO, 3 = PC4_M, 4 = WD_W, 5..7 = RF value.
- Branch, combinational on the forwarded values:
  - beq: RS_fwd == RT_fwd
  - bne: RS_fwd != RT_fwd
  - blez: signed RS_fwd <= 0
  - bgtz: signed RS_fwd > 0
  - any other op: Branch=0
- PCsrc=1 is asserted for every branch op regardless of outcome; the F stage takes the target only when Branch=1.
- Pipeline register, updated on posedge Clk:
  - if Reset or ClearE: IRE, RSE, RTE <= 0 (Reset has priority; same result)
  - else: IRE <= IRD, RSE <= RS_fwd, RTE <= RT_fwd
- Latency: control, forward and Branch outputs are 0-cycle combinational; IRE/RSE/RTE are 1 cycle.
- Power-up value and reset value of every register is 0.
- Reset asserted in the same cycle as ClearE: registers zero.

Optional Feature:
- Macro REGIMM_BRANCH_EN.
- Defined: op 000001 is decoded as a branch (EXTop=1, PCsrc=1, NPCsrc=0).
  - IRD[20:16]=00000 is bltz: Branch = signed RS_fwd < 0.
  - IRD[20:16]=00001 is bgez: Branch = signed RS_fwd >= 0.
  - Other rt codes decode to all-zero controls with Branch=0.
- Undefined: op 000001 is treated as unknown (all controls 0, Branch=0).

Test Plan:
- beq decode: IRD=0x10220003, RS_RF=RT_RF=0x5, src=0 -> EXTop=1, PCsrc=1, NPCsrc=0, Branch=1. With RT_RF=0x6 -> Branch=0.
- Forwarding: RS_RF=0, AO=0x1234, PC4_E=0x3008, PC4_M=0x300C, WD_W=0xBEEF. Sweep Fwd_RS_src 0..7 -> RS_fwd = 0, 0x3008, 0x1234, 0x300C, 0xBEEF, 0, 0, 0.
- Signed branches: bgtz with RS_fwd=0x80000000 -> Branch=0; blez with RS_fwd=0 -> Branch=1; bne with forwarded AO=1 vs RT=1 -> Branch=0.
- Jumps/decode: jal 0x0C000100 -> PCsrc=2, NPCsrc=1. jr $31 (0x03E00008) -> PCsrc=3, RS_fwd = selected value. lui -> EXTop=2. ori -> EXTop=0. Unknown op 0x3F -> all 0.
- Pipeline register: load IRD=0x8C220004 -> IRE=0x8C220004 next cycle. ClearE=1 -> IRE=RSE=RTE=0 next cycle. Reset=1 with ClearE=0 -> all 0.
- REGIMM_BRANCH_EN defined: bltz with RS_fwd=0xFFFFFFFF -> Branch=1; bgez with RS_fwd=0 -> Branch=1. Undefined: both cases -> PCsrc=0, Branch=0.
